// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative HI/LO unit for MULT/MULTU/DIV/DIVU/MTHI/MTLO.
// Radix-2 shift-add multiply and restoring divide on operand magnitudes,
// one bit per cycle. Signs are reapplied in FINISH.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for a request; MTHI/MTLO complete here in one edge
// MUL    | DATA_WIDTH shift-add iterations on magnitudes
// DIV    | DATA_WIDTH restoring-divide iterations on magnitudes
// FINISH | apply signs, write HI/LO; done pulses in the following cycle
module mult_div_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_start,
    input  logic [5:0]            i_opcode,
    input  logic [5:0]            i_funct,
    input  logic [DATA_WIDTH-1:0] i_op1,
    input  logic [DATA_WIDTH-1:0] i_op2,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [DATA_WIDTH-1:0] o_hi,
    output logic [DATA_WIDTH-1:0] o_lo
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH);

    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MTLO  = 6'b010011;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FINISH
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [CW-1:0]   r_cnt;
    logic [W-1:0]    r_acc_hi;
    logic [W-1:0]    r_acc_lo;
    logic [W-1:0]    r_opb;
    logic [W-1:0]    r_hi;
    logic [W-1:0]    r_lo;
    logic            r_is_div;
    logic            r_neg_q;
    logic            r_neg_r;
    logic            r_done;

    logic            w_is_mul;
    logic            w_is_div;
    logic            w_is_signed;
    logic            w_mthi;
    logic            w_mtlo;
    logic            w_accept;
    logic            w_sign1;
    logic            w_sign2;
    logic [W-1:0]    w_mag1;
    logic [W-1:0]    w_mag2;

    logic [W:0]      w_sum;
    logic [W:0]      w_trial;
    logic            w_ge;
    logic [W-1:0]    w_diff;

    logic [2*W-1:0]  w_prod;
    logic [2*W-1:0]  w_prod_fix;
    logic [W-1:0]    w_quot;
    logic [W-1:0]    w_rem;

    assign w_is_mul    = (i_funct == F_MULT) || (i_funct == F_MULTU);
    assign w_is_div    = (i_funct == F_DIV)  || (i_funct == F_DIVU);
    assign w_is_signed = (i_funct == F_MULT) || (i_funct == F_DIV);
    assign w_mthi      = (i_funct == F_MTHI);
    assign w_mtlo      = (i_funct == F_MTLO);
    assign w_accept    = i_start && (r_state == S_IDLE) && (i_opcode == 6'd0) &&
                         (w_is_mul || w_is_div || w_mthi || w_mtlo);

    // Magnitudes: 0x80000000 negates to itself, which is the correct unsigned magnitude.
    assign w_sign1 = w_is_signed & i_op1[W-1];
    assign w_sign2 = w_is_signed & i_op2[W-1];
    assign w_mag1  = w_sign1 ? (~i_op1 + 1'b1) : i_op1;
    assign w_mag2  = w_sign2 ? (~i_op2 + 1'b1) : i_op2;

    // Multiply step: add multiplicand when the multiplier LSB is set, then shift right.
    assign w_sum   = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_opb} : '0);

    // Divide step: shift next dividend bit into the partial remainder and trial-subtract.
    // A zero divisor always "fits", yielding all-ones quotient and remainder = dividend.
    assign w_trial = {r_acc_hi, r_acc_lo[W-1]};
    assign w_ge    = (w_trial >= {1'b0, r_opb});
    assign w_diff  = w_trial[W-1:0] - r_opb;

    assign w_prod     = {r_acc_hi, r_acc_lo};
    assign w_prod_fix = r_neg_q ? (~w_prod + 1'b1) : w_prod;
    assign w_quot     = r_neg_q ? (~r_acc_lo + 1'b1) : r_acc_lo;
    assign w_rem      = r_neg_r ? (~r_acc_hi + 1'b1) : r_acc_hi;

    // State register.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic: iteration phases end on counter terminal count.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept && w_is_mul) begin
                    w_next = S_MUL;
                end else if (w_accept && w_is_div) begin
                    w_next = S_DIV;
                end
            end
            S_MUL, S_DIV: begin
                if (r_cnt == '0) begin
                    w_next = S_FINISH;
                end
            end
            S_FINISH: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Datapath: operand latch, iteration, sign fix-up and HI/LO write-back.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_cnt    <= '0;
            r_acc_hi <= '0;
            r_acc_lo <= '0;
            r_opb    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= (r_state == S_FINISH);
            case (r_state)
                S_IDLE: begin
                    if (w_accept && w_mthi) begin
                        r_hi <= i_op1;
                    end
                    if (w_accept && w_mtlo) begin
                        r_lo <= i_op1;
                    end
                    if (w_accept && w_is_mul) begin
                        r_acc_hi <= '0;
                        r_acc_lo <= w_mag2;
                        r_opb    <= w_mag1;
                        r_neg_q  <= w_sign1 ^ w_sign2;
                        r_neg_r  <= 1'b0;
                        r_is_div <= 1'b0;
                        r_cnt    <= CW'(W - 1);
                    end
                    if (w_accept && w_is_div) begin
                        r_acc_hi <= '0;
                        r_acc_lo <= w_mag1;
                        r_opb    <= w_mag2;
                        // Divide by zero leaves the all-ones quotient un-negated.
                        r_neg_q  <= (w_sign1 ^ w_sign2) && (i_op2 != '0);
                        r_neg_r  <= w_sign1;
                        r_is_div <= 1'b1;
                        r_cnt    <= CW'(W - 1);
                    end
                end
                S_MUL: begin
                    r_acc_hi <= w_sum[W:1];
                    r_acc_lo <= {w_sum[0], r_acc_lo[W-1:1]};
                    r_cnt    <= r_cnt - 1'b1;
                end
                S_DIV: begin
                    r_acc_hi <= w_ge ? w_diff : w_trial[W-1:0];
                    r_acc_lo <= {r_acc_lo[W-2:0], w_ge};
                    r_cnt    <= r_cnt - 1'b1;
                end
                S_FINISH: begin
                    if (r_is_div) begin
                        r_hi <= w_rem;
                        r_lo <= w_quot;
                    end else begin
                        r_hi <= w_prod_fix[2*W-1:W];
                        r_lo <= w_prod_fix[W-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_busy = (r_state != S_IDLE);
    assign o_done = r_done;
    assign o_hi   = r_hi;
    assign o_lo   = r_lo;

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
Sequential MIPS HI/LO unit that executes MULT, MULTU, DIV, DIVU, MTHI and MTLO using iterative radix-2 shift-add multiply and restoring divide, one bit per cycle. It sits beside the combinational ALU/shifter in the execute stage. It takes the same decoded opcode/funct and rs/rt operands the ALU takes. It owns the architectural HI and LO registers, which MFHI/MFLO read directly. The issue logic stalls on busy.

Parameters:
DATA_WIDTH, 32, operand/HI/LO width; iteration count equals DATA_WIDTH.

Ports:
clk  input  1  single clock; all state updates on rising edge.
reset  input  1  asynchronous, active-high reset.
start  input  1  request strobe, sampled on rising clk edge.
opcode  input  6  instruction opcode; only 6'b000000 (SPECIAL) is accepted.
funct  input  6  MULT 011000, MULTU 011001, DIV 011010, DIVU 011011, MTHI 010001, MTLO 010011.
op1  input  DATA_WIDTH  rs value: multiplicand/dividend, or MTHI/MTLO source.
op2  input  DATA_WIDTH  rt value: multiplier/divisor.
busy  output  1  high while a mul/div is in flight.
done  output  1  one-cycle pulse when HI/LO hold a new mul/div result.
hi  output  DATA_WIDTH  architectural HI register.
lo  output  DATA_WIDTH  architectural LO register.

Behaviour:
- Reset (async, active-high):
  - state=IDLE; busy=0, done=0, hi=0, lo=0.
  - All iteration state cleared.
  - Reset mid-operation aborts the operation; no partial result is written.
- Accept condition: start && !busy && opcode==0 && funct is one of the six codes above.
  - Anything else is ignored: no state change, no done.
  - start while busy is dropped, not queued.
- MTHI/MTLO: at the accepting edge, hi<=op1 (MTHI) or lo<=op1 (MTLO). busy stays 0, no done pulse, single cycle.
- FSM states: IDLE, MUL, DIV, FINISH.
  - IDLE -> MUL or DIV on accept. Operands are latched at that edge, so op1/op2 may change afterwards.
  - MUL/DIV run exactly DATA_WIDTH cycles (iteration counter 0..31), then go to FINISH.
  - FINISH lasts 1 cycle, then returns to IDLE.
- Timing, with accept sampled at edge of cycle n:
  - busy=1 in cycles n+1..n+33.
  - HI/LO written at the edge ending cycle n+33.
  - In cycle n+34: done=1, busy=0, new hi/lo visible. A new start is accepted in cycle n+34.
  - hi/lo keep their old values for the whole operation.
- Signed ops (MULT, DIV):
  - Operands are converted to magnitudes at accept; the core is unsigned.
  - MULT: 64-bit product negated in FINISH if sign(op1)^sign(op2).
  - DIV: quotient negated if sign(op1)^sign(op2); remainder takes the sign of the dividend (truncating division).
- Result mapping:
  - MULT/MULTU: hi = product[63:32], lo = product[31:0].
  - DIV/DIVU: lo = quotient, hi = remainder.
- Divide by zero (DIVU): full latency still used; lo=0xFFFFFFFF, hi=op1.
- Divide by zero (DIV): lo=0xFFFFFFFF, hi=op1 unmodified.
- Overflow: DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0 (wraps, no trap).
- Magnitude of 0x80000000 is 0x80000000 as unsigned; the core must handle it correctly.

Test Plan:
- MULT op1=0xFFFFFFFF, op2=0x00000002 -> done in cycle n+34, hi=0xFFFFFFFF, lo=0xFFFFFFFE; busy high for exactly 33 cycles.
- MULTU op1=0xFFFFFFFF, op2=0x00000002 -> hi=0x00000001, lo=0xFFFFFFFE. MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- DIV op1=0xFFFFFFF9 (-7), op2=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7/0 -> lo=0xFFFFFFFF, hi=7. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- MTHI op1=0x12345678 then MTLO op1=0x9ABCDEF0 on consecutive cycles -> hi/lo updated the next cycle each, busy and done never asserted.
- Start MULTU 3x5. Assert start DIVU in cycle n+10 with operands changing after accept, and start with opcode=0x08 -> only the first op completes: hi=0, lo=15, exactly one done pulse.
- Reset asserted asynchronously (between clock edges) in cycle n+20 of a MULT -> busy, done, hi, lo go to 0 immediately. Next MULTU 6x7 -> lo=42, hi=0.
